fpu_exception_unit: RTL and testbench

Parametrised, pipelined special-value handler for the FPU add/sub/mul datapath. It classifies both operands (zero, infinity, NaN, finite) for any IEEE-754-style format. It produces the IEEE-mandated result and an exception flag for special cases. It accumulates sticky status flags. The block sits in parallel with the arithmetic core; the core's result mux selects this block's `result` whenever `exception` is high on `out_valid`.

---
 rtl/fpu_exception_unit.sv | 164 ++++++++++++++++
 tb/tb_fpu_exception_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_exception_unit.sv
// ============================================================================
//  Module   : fpu_exception_unit
//  Purpose  : Pipelined IEEE-754 special-value handler (NaN/Inf/zero) for
//             add/sub/mul; optional exception counter via FPU_EXC_CNT_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fpu_exception_unit #(
   parameter int EXP_W       = 8,
   parameter int MAN_W       = 23,
   parameter int PIPE_STAGES = 1
) (
   input  logic                   clk,
   input  logic                   arst,
   input  logic                   in_valid,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   input  logic [1:0]             op,
   input  logic                   flags_clr,
   output logic                   out_valid,
   output logic                   exception,
   output logic [EXP_W+MAN_W:0]   result,
   output logic [3:0]             flags
`ifdef FPU_EXC_CNT_EN
   ,
   output logic [15:0]            exc_count
`endif
);

   localparam int W = 1 + EXP_W + MAN_W;
   localparam logic [W-1:0] c_CAN_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   logic [W-1:0] w_b_eff;
   logic         w_a_s, w_be_s;
   logic         w_a_zero, w_a_inf, w_a_nan;
   logic         w_b_zero, w_b_inf, w_b_nan;
   logic [W-1:0] w_res;
   logic         w_exc;
   logic [3:0]   w_ev;

   logic         r_vld [1:PIPE_STAGES];
   logic         r_exc [1:PIPE_STAGES];
   logic [W-1:0] r_res [1:PIPE_STAGES];
   logic [3:0]   r_ev  [1:PIPE_STAGES];
   logic [3:0]   r_flags;

   assign w_b_eff  = (op == 2'b01) ? {~b[W-1], b[W-2:0]} : b;
   assign w_a_s    = a[W-1];
   assign w_be_s   = w_b_eff[W-1];

   assign w_a_zero = (a[W-2:MAN_W] == '0) && (a[MAN_W-1:0] == '0);
   assign w_a_inf  = (&a[W-2:MAN_W]) && (a[MAN_W-1:0] == '0);
   assign w_a_nan  = (&a[W-2:MAN_W]) && (a[MAN_W-1:0] != '0);
   assign w_b_zero = (b[W-2:MAN_W] == '0) && (b[MAN_W-1:0] == '0);
   assign w_b_inf  = (&b[W-2:MAN_W]) && (b[MAN_W-1:0] == '0);
   assign w_b_nan  = (&b[W-2:MAN_W]) && (b[MAN_W-1:0] != '0);

   // Event bits are {NV, NI, IR, ZI}; every special case raises exactly one.
   always_comb begin
      w_res = '0;
      w_exc = 1'b0;
      w_ev  = 4'b0000;
      case (op)
         2'b00, 2'b01: begin
            if (w_a_nan || w_b_nan) begin
               w_res = c_CAN_NAN; w_exc = 1'b1; w_ev = 4'b0100;
            end else if (w_a_inf && w_b_inf && (w_a_s != w_be_s)) begin
               w_res = c_CAN_NAN; w_exc = 1'b1; w_ev = 4'b1000;
            end else if (w_a_inf) begin
               w_res = a; w_exc = 1'b1; w_ev = 4'b0010;
            end else if (w_b_inf) begin
               w_res = w_b_eff; w_exc = 1'b1; w_ev = 4'b0010;
            end else if (w_a_zero && w_b_zero) begin
               w_res = {w_a_s & w_be_s, {(W-1){1'b0}}}; w_exc = 1'b1; w_ev = 4'b0001;
            end else if (w_a_zero) begin
               w_res = w_b_eff; w_exc = 1'b1; w_ev = 4'b0001;
            end else if (w_b_zero) begin
               w_res = a; w_exc = 1'b1; w_ev = 4'b0001;
            end
         end
         2'b10: begin
            if (w_a_nan || w_b_nan) begin
               w_res = c_CAN_NAN; w_exc = 1'b1; w_ev = 4'b0100;
            end else if ((w_a_inf && w_b_zero) || (w_a_zero && w_b_inf)) begin
               w_res = c_CAN_NAN; w_exc = 1'b1; w_ev = 4'b1000;
            end else if (w_a_inf || w_b_inf) begin
               w_res = {w_a_s ^ b[W-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
               w_exc = 1'b1; w_ev = 4'b0010;
            end else if (w_a_zero || w_b_zero) begin
               w_res = {w_a_s ^ b[W-1], {(W-1){1'b0}}}; w_exc = 1'b1; w_ev = 4'b0001;
            end
         end
         default: begin
            w_res = c_CAN_NAN; w_exc = 1'b1; w_ev = 4'b1000;
         end
      endcase
   end

   // Stage 1 captures the classified result; later stages only delay it.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         for (int k = 1; k <= PIPE_STAGES; k++) begin
            r_vld[k] <= 1'b0;
            r_exc[k] <= 1'b0;
            r_res[k] <= '0;
            r_ev[k]  <= 4'b0000;
         end
      end else begin
         r_vld[1] <= in_valid;
         if (in_valid) begin
            r_res[1] <= w_res;
            r_exc[1] <= w_exc;
            r_ev[1]  <= w_ev;
         end
         for (int k = 2; k <= PIPE_STAGES; k++) begin
            r_vld[k] <= r_vld[k-1];
            if (r_vld[k-1]) begin
               r_res[k] <= r_res[k-1];
               r_exc[k] <= r_exc[k-1];
               r_ev[k]  <= r_ev[k-1];
            end
         end
      end
   end

   // A clear coinciding with an output leaves exactly that output's events.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_flags <= 4'b0000;
      end else if (flags_clr) begin
         r_flags <= r_vld[PIPE_STAGES] ? r_ev[PIPE_STAGES] : 4'b0000;
      end else if (r_vld[PIPE_STAGES]) begin
         r_flags <= r_flags | r_ev[PIPE_STAGES];
      end
   end

`ifdef FPU_EXC_CNT_EN
   logic [15:0] r_cnt;
   logic        w_cnt_inc;

   assign w_cnt_inc = r_vld[PIPE_STAGES] && r_exc[PIPE_STAGES];

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_cnt <= 16'h0000;
      end else if (flags_clr) begin
         r_cnt <= {15'h0000, w_cnt_inc};
      end else if (w_cnt_inc && (r_cnt != 16'hFFFF)) begin
         r_cnt <= r_cnt + 16'h0001;
      end
   end

   assign exc_count = r_cnt;
`endif

   assign out_valid = r_vld[PIPE_STAGES];
   assign exception = r_exc[PIPE_STAGES];
   assign result    = r_res[PIPE_STAGES];
   assign flags     = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_fpu_exception_unit.sv
// ============================================================================
//  Module   : tb_fpu_exception_unit
//  Purpose  : Randomized scoreboard bench for fpu_exception_unit (single
//             precision, 2 stages) plus a half-precision spot check.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fpu_exception_unit;

   localparam logic [31:0] NAN32 = 32'h7FC00000;

   typedef struct {
      logic [31:0] res;
      logic        exc;
      logic [3:0]  ev;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        arst = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] a = '0, b = '0;
   logic [1:0]  op = '0;
   logic        flags_clr = 1'b0;
   logic        out_valid, exception;
   logic [31:0] result;
   logic [3:0]  flags;

   logic        h_in_valid = 1'b0;
   logic [15:0] h_a = '0, h_b = '0;
   logic [1:0]  h_op = '0;
   logic        h_out_valid, h_exception;
   logic [15:0] h_result;
   logic [3:0]  h_flags;

`ifdef FPU_EXC_CNT_EN
   logic [15:0] exc_count, h_exc_count;
   logic [15:0] mcnt = '0;
`endif

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t q[$];
   exp_t me;
   logic [3:0]  mflags = '0;
   logic [31:0] last_res = '0;
   logic        last_exc = 1'b0;
   logic [3:0]  cur_ev;
   logic        cur_inc;

   fpu_exception_unit #(.EXP_W(8), .MAN_W(23), .PIPE_STAGES(2)) dut (
      .clk(clk), .arst(arst), .in_valid(in_valid), .a(a), .b(b), .op(op),
      .flags_clr(flags_clr), .out_valid(out_valid), .exception(exception),
      .result(result), .flags(flags)
`ifdef FPU_EXC_CNT_EN
      , .exc_count(exc_count)
`endif
   );

   fpu_exception_unit #(.EXP_W(5), .MAN_W(10), .PIPE_STAGES(1)) dut_h (
      .clk(clk), .arst(arst), .in_valid(h_in_valid), .a(h_a), .b(h_b), .op(h_op),
      .flags_clr(1'b0), .out_valid(h_out_valid), .exception(h_exception),
      .result(h_result), .flags(h_flags)
`ifdef FPU_EXC_CNT_EN
      , .exc_count(h_exc_count)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // 0 zero, 1 finite, 2 inf, 3 nan
   function automatic int cls(input logic [31:0] x);
      if (x[30:23] == 8'hFF) return (x[22:0] == 0) ? 2 : 3;
      if (x[30:0] == 0) return 0;
      return 1;
   endfunction

   function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic [1:0] o);
      exp_t r;
      int   ca, cb;
      logic sa, sb;
      ca = cls(x); cb = cls(y);
      sa = x[31];
      sb = (o == 2'b01) ? ~y[31] : y[31];
      r.res = '0; r.exc = 1'b1; r.ev = 4'b0000; r.cyc = cyc;
      if (o == 2'b11) begin
         r.res = NAN32; r.ev = 4'b1000;
      end else if (ca == 3 || cb == 3) begin
         r.res = NAN32; r.ev = 4'b0100;
      end else if (o == 2'b10) begin
         if ((ca == 2 && cb == 0) || (ca == 0 && cb == 2)) begin
            r.res = NAN32; r.ev = 4'b1000;
         end else if (ca == 2 || cb == 2) begin
            r.res = {sa ^ sb, 8'hFF, 23'h0}; r.ev = 4'b0010;
         end else if (ca == 0 || cb == 0) begin
            r.res = {sa ^ sb, 31'h0}; r.ev = 4'b0001;
         end else r.exc = 1'b0;
      end else begin
         if (ca == 2 && cb == 2 && sa != sb) begin
            r.res = NAN32; r.ev = 4'b1000;
         end else if (ca == 2) begin
            r.res = x; r.ev = 4'b0010;
         end else if (cb == 2) begin
            r.res = {sb, y[30:0]}; r.ev = 4'b0010;
         end else if (ca == 0 && cb == 0) begin
            r.res = {sa & sb, 31'h0}; r.ev = 4'b0001;
         end else if (ca == 0) begin
            r.res = {sb, y[30:0]}; r.ev = 4'b0001;
         end else if (cb == 0) begin
            r.res = x; r.ev = 4'b0001;
         end else r.exc = 1'b0;
      end
      return r;
   endfunction

   function automatic logic [31:0] rnd_operand();
      logic        s;
      logic [22:0] m;
      logic [7:0]  e;
      s = 1'($urandom_range(0, 1));
      m = 23'($urandom);
      e = 8'($urandom_range(1, 254));
      case ($urandom_range(0, 5))
         0:       return {s, 31'h0};
         1:       return {s, 8'hFF, 23'h0};
         2:       return {s, 8'hFF, (m == 0) ? 23'h1 : m};
         3:       return {s, 8'h00, (m == 0) ? 23'h1 : m};
         default: return {s, e, m};
      endcase
   endfunction

   task automatic drive(input logic v, input logic [31:0] xa, input logic [31:0] xb,
                        input logic [1:0] xop, input logic clr);
      in_valid = v; a = xa; b = xb; op = xop; flags_clr = clr;
      if (v) q.push_back(model(xa, xb, xop));
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
   endtask

   // Scoreboard monitor: sampled on the falling edge, away from updates.
   always @(negedge clk) begin
      if (arst) begin
         mflags   = '0;
         last_res = '0;
         last_exc = 1'b0;
`ifdef FPU_EXC_CNT_EN
         mcnt = '0;
`endif
      end else begin
         chk("flags", {28'h0, flags}, {28'h0, mflags});
`ifdef FPU_EXC_CNT_EN
         chk("exc_count", {16'h0, exc_count}, {16'h0, mcnt});
`endif
         cur_ev  = 4'b0000;
         cur_inc = 1'b0;
         if (out_valid) begin
            if (q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_out_valid: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
               me = q.pop_front();
               chk("result", result, me.res);
               chk("exception", {31'h0, exception}, {31'h0, me.exc});
               chk("latency", cyc - me.cyc, 32'd2);
               cur_ev   = me.ev;
               cur_inc  = me.exc;
               last_res = me.res;
               last_exc = me.exc;
            end
         end else begin
            chk("hold_result", result, last_res);
            chk("hold_exception", {31'h0, exception}, {31'h0, last_exc});
         end
         if (flags_clr) mflags = cur_ev;
         else           mflags = mflags | cur_ev;
`ifdef FPU_EXC_CNT_EN
         if (flags_clr)                      mcnt = {15'h0, cur_inc};
         else if (cur_inc && mcnt != 16'hFFFF) mcnt = mcnt + 16'h1;
`endif
      end
   end

   initial begin
      int waited;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
      chk("reset_result", result, 32'h0);
      chk("reset_exception", {31'h0, exception}, 32'h0);
      chk("reset_flags", {28'h0, flags}, 32'h0);
      arst = 1'b0;
      @(posedge clk); #1;

      // Directed vectors from the expected behaviour list.
      drive(1'b1, 32'h7F800000, 32'hFF800000, 2'b00, 1'b0);
      idle(3);
      chk("inf_minus_inf_flags", {28'h0, flags}, 32'h8);
      drive(1'b1, 32'h00000000, 32'h00000000, 2'b01, 1'b0);
      drive(1'b1, 32'h80000000, 32'h00000000, 2'b01, 1'b0);
      drive(1'b1, 32'h7F800000, 32'h80000000, 2'b10, 1'b0);
      drive(1'b1, 32'hFF800000, 32'h3F800000, 2'b10, 1'b0);
      drive(1'b1, 32'h00000000, 32'h3F800000, 2'b01, 1'b0);
      drive(1'b1, 32'h3F800000, 32'h40000000, 2'b00, 1'b0);
      drive(1'b1, 32'h3F800000, 32'h40000000, 2'b11, 1'b0);
      idle(3);

      // Back-to-back with a clear landing on the NaN output's cycle.
      drive(1'b1, 32'h7F800000, 32'hFF800000, 2'b00, 1'b0);
      drive(1'b1, 32'h7F800001, 32'h3F800000, 2'b00, 1'b0);
      idle(1);
      drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
      chk("clear_vs_set_flags", {28'h0, flags}, 32'h4);
      idle(2);

      for (int i = 0; i < 2000; i++)
         drive(1'($urandom_range(0, 3) != 0), rnd_operand(), rnd_operand(),
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 15) == 0));
      idle(4);

      // Asynchronous reset with two operations in flight.
      drive(1'b1, 32'h7F800001, 32'h0, 2'b00, 1'b0);
      in_valid = 1'b1; a = 32'hFF800000; b = 32'h0; op = 2'b10;
      @(posedge clk); #2;
      in_valid = 1'b0;
      arst = 1'b1;
      q.delete();
      #1;
      chk("arst_out_valid", {31'h0, out_valid}, 32'h0);
      chk("arst_result", result, 32'h0);
      chk("arst_exception", {31'h0, exception}, 32'h0);
      chk("arst_flags", {28'h0, flags}, 32'h0);
      @(posedge clk); #1;
      arst = 1'b0;
      idle(5);

      // Half precision, single stage.
      h_in_valid = 1'b1; h_a = 16'h7C01; h_b = 16'h3C00; h_op = 2'b00;
      @(posedge clk); #1;
      chk("half_nan_valid", {31'h0, h_out_valid}, 32'h1);
      chk("half_nan_result", {16'h0, h_result}, 32'h7E00);
      chk("half_nan_exc", {31'h0, h_exception}, 32'h1);
      h_a = 16'h7C00; h_b = 16'h8000; h_op = 2'b10;
      @(posedge clk); #1;
      chk("half_inf_zero_result", {16'h0, h_result}, 32'h7E00);
      h_a = 16'h3C00; h_b = 16'h4000; h_op = 2'b00;
      @(posedge clk); #1;
      chk("half_finite_result", {16'h0, h_result}, 32'h0);
      chk("half_finite_exc", {31'h0, h_exception}, 32'h0);
      h_in_valid = 1'b0;
      @(posedge clk); #1;
      chk("half_idle_valid", {31'h0, h_out_valid}, 32'h0);

`ifdef FPU_EXC_CNT_EN
      idle(1);
      drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
      for (int i = 0; i < 70000; i++) drive(1'b1, 32'h7F800000, 32'h3F800000, 2'b00, 1'b0);
      idle(4);
      chk("count_saturated", {16'h0, exc_count}, 32'hFFFF);
      drive(1'b1, 32'h7F800000, 32'h0, 2'b10, 1'b0);
      idle(1);
      drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
      chk("count_clear_vs_inc", {16'h0, exc_count}, 32'h1);
`endif

      waited = 0;
      while (q.size() != 0 && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      if (q.size() != 0) begin
         checks++; errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
